// File: rtl/tim_match_tracker.sv
// tim_match_tracker: timer compare-match tracker.
// Detects the rising edge of (tim_cnt == cmp_val) in the timer count clock
// domain. On each accepted match it produces a one-cycle strobe, drives the
// output-compare pin, counts unserviced matches and runs one-pulse mode.
// The optional capture path is built only when TMT_CAPTURE_EN is defined.
// tint_clr is the timer interrupt clear and is asynchronous and active-high.
module tim_match_tracker #(
    parameter int CNT_W = 16,
    parameter int EVT_W = 8,
    parameter int RPT_W = 8
) (
    input  logic             timclk,
    input  logic             tint_clr,
    input  logic [CNT_W-1:0] tim_cnt,
    input  logic [CNT_W-1:0] cmp_val,
    input  logic [1:0]       oc_mode,
    input  logic             opm_en,
    input  logic [RPT_W-1:0] rpt_cnt,
    input  logic             cap_in,
    output logic             match_pulse,
    output logic             oc_out,
    output logic [EVT_W-1:0] evt_cnt,
    output logic             evt_ovf,
    output logic             opm_done,
    output logic [CNT_W-1:0] cap_val,
    output logic             cap_vld
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);
    localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

    state_t           state_q, state_d;
    logic             eq_q, eq_d;
    logic             pulse_q, pulse_d;
    logic             oc_q, oc_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic             ovf_q, ovf_d;
    logic [RPT_W-1:0] rpt_ctr_q, rpt_ctr_d;
    logic             done_q, done_d;
    logic             accept;
    logic [RPT_W-1:0] rpt_nxt;

    // Next-state: match edge detection, output-compare action, counters, one-pulse stop.
    always_comb begin
        eq_d      = (tim_cnt == cmp_val);
        accept    = eq_d & ~eq_q & (state_q == ST_RUN);
        rpt_nxt   = rpt_ctr_q + RPT_ONE;
        pulse_d   = accept;
        oc_d      = oc_q;
        evt_d     = evt_q;
        ovf_d     = ovf_q;
        rpt_ctr_d = rpt_ctr_q;
        state_d   = state_q;
        if (accept) begin
            case (oc_mode)
                2'b01:   oc_d = 1'b1;
                2'b10:   oc_d = 1'b0;
                2'b11:   oc_d = ~oc_q;
                default: oc_d = oc_q;
            endcase
            // Saturate so a long-ignored interrupt never reads back as a small count.
            if (evt_q != '1) begin
                evt_d = evt_q + EVT_ONE;
            end
            // A second match before the clear means the interrupt was missed.
            if (evt_q != '0) begin
                ovf_d = 1'b1;
            end
            rpt_ctr_d = rpt_nxt;
            // The stopping match itself is still fully processed.
            if (opm_en && (rpt_cnt != '0) && (rpt_nxt == rpt_cnt)) begin
                state_d = ST_DONE;
            end
        end
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs; tint_clr wipes everything immediately.
    always_ff @(posedge timclk or posedge tint_clr) begin
        if (tint_clr) begin
            state_q   <= ST_RUN;
            eq_q      <= 1'b0;
            pulse_q   <= 1'b0;
            oc_q      <= 1'b0;
            evt_q     <= '0;
            ovf_q     <= 1'b0;
            rpt_ctr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            eq_q      <= eq_d;
            pulse_q   <= pulse_d;
            oc_q      <= oc_d;
            evt_q     <= evt_d;
            ovf_q     <= ovf_d;
            rpt_ctr_q <= rpt_ctr_d;
            done_q    <= done_d;
        end
    end

    assign match_pulse = pulse_q;
    assign oc_out      = oc_q;
    assign evt_cnt     = evt_q;
    assign evt_ovf     = ovf_q;
    assign opm_done    = done_q;

`ifdef TMT_CAPTURE_EN
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             sync3_q, sync3_d;
    logic [CNT_W-1:0] cap_val_q, cap_val_d;
    logic             cap_vld_q, cap_vld_d;

    // Capture next-state: two-flop synchronizer, then rising-edge detect on the synced level.
    always_comb begin
        sync1_d   = cap_in;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        cap_val_d = cap_val_q;
        cap_vld_d = cap_vld_q;
        if (sync2_q & ~sync3_q) begin
            cap_val_d = tim_cnt;
            cap_vld_d = 1'b1;
        end
    end

    // Capture registers; capture keeps working after the one-pulse stop.
    always_ff @(posedge timclk or posedge tint_clr) begin
        if (tint_clr) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            cap_val_q <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            cap_val_q <= cap_val_d;
            cap_vld_q <= cap_vld_d;
        end
    end

    assign cap_val = cap_val_q;
    assign cap_vld = cap_vld_q;
`else
    logic unused_cap_in;
    assign unused_cap_in = cap_in;
    assign cap_val       = '0;
    assign cap_vld       = 1'b0;
`endif

endmodule

// File: tb/tb_tim_match_tracker.sv
// tb_tim_match_tracker: directed scenarios plus randomized traffic against a
// behavioural model that tracks the total number of accepted matches.
module tb_tim_match_tracker;

    localparam int CNT_W = 16;
    localparam int EVT_W = 8;
    localparam int RPT_W = 8;

    logic             timclk = 1'b0;
    logic             tint_clr;
    logic [CNT_W-1:0] tim_cnt;
    logic [CNT_W-1:0] cmp_val;
    logic [1:0]       oc_mode;
    logic             opm_en;
    logic [RPT_W-1:0] rpt_cnt;
    logic             cap_in;
    logic             match_pulse;
    logic             oc_out;
    logic [EVT_W-1:0] evt_cnt;
    logic             evt_ovf;
    logic             opm_done;
    logic [CNT_W-1:0] cap_val;
    logic             cap_vld;

    int total = 0;
    int bad   = 0;

    // reference model state
    int               n_acc;
    bit               m_prev;
    bit               m_done;
    bit               m_pulse;
    bit               m_oc;
    bit               s1, s2, s3;
    logic [CNT_W-1:0] m_cap_val;
    bit               m_cap_vld;

    tim_match_tracker #(.CNT_W(CNT_W), .EVT_W(EVT_W), .RPT_W(RPT_W)) dut (
        .timclk      (timclk),
        .tint_clr    (tint_clr),
        .tim_cnt     (tim_cnt),
        .cmp_val     (cmp_val),
        .oc_mode     (oc_mode),
        .opm_en      (opm_en),
        .rpt_cnt     (rpt_cnt),
        .cap_in      (cap_in),
        .match_pulse (match_pulse),
        .oc_out      (oc_out),
        .evt_cnt     (evt_cnt),
        .evt_ovf     (evt_ovf),
        .opm_done    (opm_done),
        .cap_val     (cap_val),
        .cap_vld     (cap_vld)
    );

    always #5 timclk = ~timclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_evt();
        return (n_acc > 255) ? 255 : n_acc;
    endfunction

    task automatic model_reset();
        n_acc = 0; m_prev = 0; m_done = 0; m_pulse = 0; m_oc = 0;
        s1 = 0; s2 = 0; s3 = 0; m_cap_val = '0; m_cap_vld = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pulse"}, 32'(match_pulse), 32'(m_pulse));
        chk({tag, ".oc"},    32'(oc_out),      32'(m_oc));
        chk({tag, ".evt"},   32'(evt_cnt),     32'(exp_evt()));
        chk({tag, ".ovf"},   32'(evt_ovf),     32'(n_acc >= 2));
        chk({tag, ".done"},  32'(opm_done),    32'(m_done));
        chk({tag, ".capv"},  32'(cap_val),     32'(m_cap_val));
        chk({tag, ".capd"},  32'(cap_vld),     32'(m_cap_vld));
    endtask

    // one timclk edge: the model consumes the inputs present at the edge
    task automatic step(input string tag);
        bit eq, acc, rise;
        @(posedge timclk);
        eq     = (tim_cnt == cmp_val);
        acc    = eq && !m_prev && !m_done;
        m_prev = eq;
        m_pulse = acc;
        if (acc) begin
            n_acc++;
            if (oc_mode == 2'b01) m_oc = 1;
            else if (oc_mode == 2'b10) m_oc = 0;
            else if (oc_mode == 2'b11) m_oc = !m_oc;
            if (opm_en && rpt_cnt != 0 && (n_acc % 256) == int'(rpt_cnt)) m_done = 1;
        end
`ifdef TMT_CAPTURE_EN
        rise = s2 && !s3;
        if (rise) begin
            m_cap_val = tim_cnt;
            m_cap_vld = 1;
        end
        s3 = s2; s2 = s1; s1 = cap_in;
`else
        rise = 0;
`endif
        #1;
        check_all(tag);
    endtask

    // asynchronous clear between edges; outputs must drop before any edge
    task automatic pulse_clr();
        #2 tint_clr = 1'b1;
        #1;
        model_reset();
        check_all("clr");
        #2 tint_clr = 1'b0;
    endtask

    task automatic match_once(input string tag);
        tim_cnt = cmp_val;
        step(tag);
        tim_cnt = cmp_val + 16'd1;
        step(tag);
    endtask

    initial begin
        tint_clr = 1'b1;
        tim_cnt = '0; cmp_val = '0; oc_mode = 2'b00; opm_en = 0; rpt_cnt = '0; cap_in = 0;
        model_reset();
        #12;
        check_all("reset");
        tint_clr = 1'b0;

        // basic match: counter ramps through the compare value
        cmp_val = 16'd5; oc_mode = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tim_cnt = CNT_W'(i);
            step("ramp");
            if (i == 5) chk("ramp_pulse_at5", 32'(match_pulse), 32'd1);
        end
        chk("ramp_evt", 32'(evt_cnt), 32'd1);
        chk("ramp_ovf", 32'(evt_ovf), 32'd0);
        chk("ramp_oc",  32'(oc_out),  32'd1);

        // two more matches, then clear mid-sequence
        match_once("pre_clr");
        match_once("pre_clr");
        chk("pre_clr_evt", 32'(evt_cnt), 32'd3);
        chk("pre_clr_oc",  32'(oc_out),  32'd1);
        pulse_clr();
        match_once("post_clr");
        chk("post_clr_evt", 32'(evt_cnt), 32'd1);

        // missed interrupt and saturation
        match_once("ovf");
        chk("ovf_evt", 32'(evt_cnt), 32'd2);
        chk("ovf_flag", 32'(evt_ovf), 32'd1);
        for (int i = 0; i < 300; i++) match_once("sat");
        chk("sat_evt", 32'(evt_cnt), 32'd255);
        chk("sat_ovf", 32'(evt_ovf), 32'd1);

        // stalled count equal to compare value gives one match only
        pulse_clr();
        tim_cnt = cmp_val;
        for (int i = 0; i < 5; i++) step("stall");
        chk("stall_evt", 32'(evt_cnt), 32'd1);

        // one-pulse mode, three shots
        pulse_clr();
        tim_cnt = 16'd0;
        opm_en = 1; rpt_cnt = 8'd3; oc_mode = 2'b11;
        for (int i = 0; i < 4; i++) begin
            match_once("opm");
            if (i == 2) begin
                chk("opm_done3", 32'(opm_done), 32'd1);
                chk("opm_oc3",   32'(oc_out),   32'd1);
            end
        end
        chk("opm_evt4", 32'(evt_cnt), 32'd3);
        opm_en = 0;

`ifdef TMT_CAPTURE_EN
        // capture latency: cap_in rises just before the edge at count 0x40
        pulse_clr();
        for (int i = 16'h3c; i < 16'h48; i++) begin
            tim_cnt = CNT_W'(i);
            if (i == 16'h40) cap_in = 1;
            step("cap");
        end
        chk("cap_vld", 32'(cap_vld), 32'd1);
        chk("cap_val", 32'(cap_val), 32'h42);
        cap_in = 0;
`else
        // capture absent: cap_in toggling has no effect
        for (int i = 0; i < 20; i++) begin
            cap_in = ~cap_in;
            tim_cnt = CNT_W'(i);
            step("nocap");
        end
        chk("nocap_vld", 32'(cap_vld), 32'd0);
        chk("nocap_val", 32'(cap_val), 32'd0);
`endif

        // randomized traffic
        pulse_clr();
        cmp_val = 16'd1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) cmp_val = CNT_W'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) oc_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) opm_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) rpt_cnt = RPT_W'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) cap_in = ~cap_in;
            tim_cnt = CNT_W'($urandom_range(0, 3));
            step("rnd");
            if ($urandom_range(0, 199) == 0) pulse_clr();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
